// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the alu_seq execute unit.
//   op codes   : OP_ADD, OP_NAND, OP_SUB, OP_MUL
//   cond codes : COND_ALWAYS, COND_C, COND_Z, COND_NEVER
//   state_t    : control state; the BUSY state exists only when ALU_MUL_EN
//                is defined (iterative multiplier present).
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_C      = 2'b01;
  localparam logic [1:0] COND_Z      = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

`ifdef ALU_MUL_EN
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
`else
  typedef enum logic {ST_IDLE} state_t;
`endif

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load a/b and begin WIDTH iterations (ignored while running)
//   a, b       : multiplicand, multiplier
//   done       : high during the final iteration cycle
//   product    : 2*WIDTH product; holds the complete result while done=1
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;
  logic               run_reg;

  // product is the accumulator after this cycle's partial product, so on the
  // last iteration the caller can capture the full result at the same edge.
  assign product = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done    = run_reg && (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      run_reg    <= 1'b0;
    end else if (start && !run_reg) begin
      acc_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      cnt_reg    <= '0;
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (done) run_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with carry/zero flag registers, conditional
// execution and a valid/ready input handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake, accepted when both high
//   op, cond            : operation and execution condition
//   in1, in2            : operands
//   flags_load/flags_in : direct {carry, zero} overwrite, wins over commits
//   result              : registered result, held between operations
//   out_valid, wb_en    : completion pulse; wb_en=1 when the op was taken
//   carry_flag/zero_flag: architectural flags
//   neg                 : result sign bit
//   busy                : multi-cycle multiply in progress
// Build option: define ALU_MUL_EN to enable the iterative multiplier for
// op 11; otherwise op 11 completes in one cycle as a skipped operation.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [1:0]       cond,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flags_load,
  input  logic [1:0]       flags_in,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             wb_en,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             neg,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             carry_reg, carry_next;
  logic             zero_reg, zero_next;
  logic             out_valid_reg, out_valid_next;
  logic             wb_en_reg, wb_en_next;

  logic             accept;
  logic             cond_ok;
  logic             is_sub;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nand_res;

  assign in_ready = (state_reg == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // SUB reuses the adder as in1 + ~in2 + 1, so carry-out means "no borrow".
  assign is_sub   = (op == OP_SUB);
  assign addend   = is_sub ? ~in2 : in2;
  assign sum      = {1'b0, in1} + {1'b0, addend} + {{WIDTH{1'b0}}, is_sub};
  assign nand_res = ~(in1 & in2);

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_ALWAYS: cond_ok = 1'b1;
      COND_C:      cond_ok = carry_reg;
      COND_Z:      cond_ok = zero_reg;
      default:     cond_ok = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (in1),
    .b       (in2),
    .done    (mul_done),
    .product (mul_product)
  );

  assign busy = (state_reg == ST_BUSY);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    result_next    = result_reg;
    carry_next     = carry_reg;
    zero_next      = zero_reg;
    out_valid_next = 1'b0;
    wb_en_next     = 1'b0;
`ifdef ALU_MUL_EN
    mul_start      = 1'b0;
`endif

    if (accept) begin
      // A skipped op still reports completion so the sequencer can advance.
      out_valid_next = 1'b1;
      if (cond_ok) begin
        case (op)
          OP_ADD, OP_SUB: begin
            result_next = sum[WIDTH-1:0];
            carry_next  = sum[WIDTH];
            zero_next   = (sum[WIDTH-1:0] == '0);
            wb_en_next  = 1'b1;
          end
          OP_NAND: begin
            result_next = nand_res;
            zero_next   = (nand_res == '0);
            wb_en_next  = 1'b1;
          end
          default: begin
`ifdef ALU_MUL_EN
            // Completion is reported by the multiplier, not at acceptance.
            out_valid_next = 1'b0;
            mul_start      = 1'b1;
            state_next     = ST_BUSY;
`endif
          end
        endcase
      end
    end

`ifdef ALU_MUL_EN
    if (state_reg == ST_BUSY && mul_done) begin
      result_next    = mul_product[WIDTH-1:0];
      carry_next     = |mul_product[2*WIDTH-1:WIDTH];
      zero_next      = (mul_product[WIDTH-1:0] == '0);
      out_valid_next = 1'b1;
      wb_en_next     = 1'b1;
      state_next     = ST_IDLE;
    end
`endif

    if (flags_load) begin
      carry_next = flags_in[1];
      zero_next  = flags_in[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      wb_en_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      result_reg    <= result_next;
      carry_reg     <= carry_next;
      zero_reg      <= zero_next;
      out_valid_reg <= out_valid_next;
      wb_en_reg     <= wb_en_next;
    end
  end

  assign result     = result_reg;
  assign out_valid  = out_valid_reg;
  assign wb_en      = wb_en_reg;
  assign carry_flag = carry_reg;
  assign zero_flag  = zero_reg;
  assign neg        = result_reg[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=16).
// Multiplier scenarios are selected by ALU_MUL_EN, matching the DUT build.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [1:0]   cond = 2'b00;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         flags_load = 1'b0;
  logic [1:0]   flags_in = 2'b00;
  logic [W-1:0] result;
  logic         out_valid, wb_en, carry_flag, zero_flag, neg, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cond(cond), .in1(in1), .in2(in2),
    .flags_load(flags_load), .flags_in(flags_in),
    .result(result), .out_valid(out_valid), .wb_en(wb_en),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .neg(neg), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [1:0] c,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; op = o; cond = c; in1 = a; in2 = b;
    step();
    in_valid = 1'b0;
    $display("txn op=%0d cond=%0d in1=%h in2=%h -> result=%h c=%b z=%b ov=%b wb=%b",
             o, c, a, b, result, carry_flag, zero_flag, out_valid, wb_en);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    total_cnt++; if (result !== 16'h0000) $display("FAIL rst_result got %h want 0000", result); else pass_cnt++;
    total_cnt++; if ({carry_flag, zero_flag} !== 2'b00) $display("FAIL rst_flags got %b want 00", {carry_flag, zero_flag}); else pass_cnt++;
    total_cnt++; if ({out_valid, wb_en} !== 2'b00) $display("FAIL rst_ov_wb got %b want 00", {out_valid, wb_en}); else pass_cnt++;
    total_cnt++; if ({in_ready, busy} !== 2'b10) $display("FAIL rst_ready_busy got %b want 10", {in_ready, busy}); else pass_cnt++;
  endtask

  task automatic test_add();
    issue(OP_ADD, COND_ALWAYS, 16'hFFFF, 16'h0001);
    total_cnt++; if (result !== 16'h0000) $display("FAIL add_result got %h want 0000", result); else pass_cnt++;
    total_cnt++; if ({carry_flag, zero_flag} !== 2'b11) $display("FAIL add_flags got %b want 11", {carry_flag, zero_flag}); else pass_cnt++;
    total_cnt++; if ({out_valid, wb_en} !== 2'b11) $display("FAIL add_ov_wb got %b want 11", {out_valid, wb_en}); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL add_pulse got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_sub_skip();
    issue(OP_SUB, COND_ALWAYS, 16'h0005, 16'h0007);
    total_cnt++; if (result !== 16'hFFFE) $display("FAIL sub_result got %h want fffe", result); else pass_cnt++;
    total_cnt++; if ({carry_flag, zero_flag, neg} !== 3'b001) $display("FAIL sub_c_z_neg got %b want 001", {carry_flag, zero_flag, neg}); else pass_cnt++;
    // zero=0, so the conditional NAND is skipped
    issue(OP_NAND, COND_Z, 16'h1234, 16'h5678);
    total_cnt++; if ({out_valid, wb_en} !== 2'b10) $display("FAIL skip_ov_wb got %b want 10", {out_valid, wb_en}); else pass_cnt++;
    total_cnt++; if (result !== 16'hFFFE) $display("FAIL skip_result got %h want fffe", result); else pass_cnt++;
    // 7 - 5: no borrow
    issue(OP_SUB, COND_ALWAYS, 16'h0007, 16'h0005);
    total_cnt++; if ({result, carry_flag, zero_flag} !== {16'h0002, 2'b10}) $display("FAIL sub2 got %h/%b want 0002/10", result, {carry_flag, zero_flag}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Sets carry=1, zero=1; the following ops are accepted on consecutive edges.
    in_valid = 1'b1; op = OP_ADD; cond = COND_ALWAYS; in1 = 16'hFFFF; in2 = 16'h0001;
    step();
    op = OP_NAND; cond = COND_Z; in1 = 16'h00F0; in2 = 16'h0F0F;
    step();
    total_cnt++; if ({result, carry_flag, zero_flag, wb_en} !== {16'hFFFF, 3'b101}) $display("FAIL b2b_nand got %h/%b want ffff/101", result, {carry_flag, zero_flag, wb_en}); else pass_cnt++;
    op = OP_ADD; cond = COND_C; in1 = 16'h0002; in2 = 16'h0003;
    step();
    total_cnt++; if ({result, carry_flag, zero_flag, wb_en} !== {16'h0005, 3'b001}) $display("FAIL b2b_addc got %h/%b want 0005/001", result, {carry_flag, zero_flag, wb_en}); else pass_cnt++;
    op = OP_ADD; cond = COND_C; in1 = 16'h0010; in2 = 16'h0010;
    step();
    total_cnt++; if ({result, out_valid, wb_en} !== {16'h0005, 2'b10}) $display("FAIL b2b_addc_skip got %h/%b want 0005/10", result, {out_valid, wb_en}); else pass_cnt++;
    op = OP_ADD; cond = COND_NEVER;
    step();
    in_valid = 1'b0;
    total_cnt++; if ({result, out_valid, wb_en} !== {16'h0005, 2'b10}) $display("FAIL b2b_never got %h/%b want 0005/10", result, {out_valid, wb_en}); else pass_cnt++;
    $display("txn back_to_back done result=%h", result);
  endtask

  task automatic test_flags_load();
    flags_load = 1'b1; flags_in = 2'b10;
    issue(OP_ADD, COND_ALWAYS, 16'h0001, 16'h0001);
    flags_load = 1'b0;
    total_cnt++; if ({result, carry_flag, zero_flag} !== {16'h0002, 2'b10}) $display("FAIL fload_win got %h/%b want 0002/10", result, {carry_flag, zero_flag}); else pass_cnt++;
    flags_load = 1'b1; flags_in = 2'b01;
    step();
    flags_load = 1'b0;
    total_cnt++; if ({carry_flag, zero_flag, out_valid} !== 3'b010) $display("FAIL fload_only got %b want 010", {carry_flag, zero_flag, out_valid}); else pass_cnt++;
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    int bad;
    issue(OP_MUL, COND_ALWAYS, 16'h0100, 16'h0100);
    // Competing ADD held while busy
    in_valid = 1'b1; op = OP_ADD; cond = COND_ALWAYS; in1 = 16'h0003; in2 = 16'h0004;
    bad = 0;
    for (int i = 1; i <= W; i++) begin
      if ({busy, in_ready, out_valid} !== 3'b100) bad++;
      step();
    end
    total_cnt++; if (bad != 0) $display("FAIL mul_busy_window got %0d bad cycles want 0", bad); else pass_cnt++;
    total_cnt++; if ({result, carry_flag, zero_flag, out_valid, wb_en} !== {16'h0000, 4'b1111}) $display("FAIL mul_result got %h/%b want 0000/1111", result, {carry_flag, zero_flag, out_valid, wb_en}); else pass_cnt++;
    total_cnt++; if ({busy, in_ready} !== 2'b01) $display("FAIL mul_idle got %b want 01", {busy, in_ready}); else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++; if ({result, carry_flag, zero_flag, out_valid} !== {16'h0007, 3'b001}) $display("FAIL mul_then_add got %h/%b want 0007/001", result, {carry_flag, zero_flag, out_valid}); else pass_cnt++;
    $display("txn mul 0100x0100 then add done");

    issue(OP_MUL, COND_ALWAYS, 16'h0003, 16'h0004);
    for (int i = 1; i <= W; i++) step();
    total_cnt++; if ({result, carry_flag, zero_flag, out_valid} !== {16'h000C, 3'b001}) $display("FAIL mul_small got %h/%b want 000c/001", result, {carry_flag, zero_flag, out_valid}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul();
    int ov_seen;
    flags_load = 1'b1; flags_in = 2'b11;
    step();
    flags_load = 1'b0;
    issue(OP_MUL, COND_ALWAYS, 16'h0100, 16'h0100);
    for (int i = 1; i < 8; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++; if ({busy, in_ready, out_valid, carry_flag, zero_flag} !== 5'b01000) $display("FAIL rst_mid_mul got %b want 01000", {busy, in_ready, out_valid, carry_flag, zero_flag}); else pass_cnt++;
    ov_seen = 0;
    for (int i = 0; i < W + 2; i++) begin
      if (out_valid) ov_seen++;
      step();
    end
    total_cnt++; if (ov_seen != 0) $display("FAIL rst_mid_mul_ov got %0d want 0", ov_seen); else pass_cnt++;
    $display("txn reset mid-mul done");
  endtask
`else
  task automatic test_mul_disabled();
    flags_load = 1'b1; flags_in = 2'b10;
    step();
    flags_load = 1'b0;
    issue(OP_MUL, COND_ALWAYS, 16'h0003, 16'h0004);
    total_cnt++; if ({out_valid, wb_en} !== 2'b10) $display("FAIL mul_off_ov_wb got %b want 10", {out_valid, wb_en}); else pass_cnt++;
    total_cnt++; if ({carry_flag, zero_flag, result} !== {2'b10, 16'h0002}) $display("FAIL mul_off_state got %b/%h want 10/0002", {carry_flag, zero_flag}, result); else pass_cnt++;
    total_cnt++; if ({busy, in_ready} !== 2'b01) $display("FAIL mul_off_busy got %b want 01", {busy, in_ready}); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub_skip();
    test_back_to_back();
    test_flags_load();
`ifdef ALU_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_mul_disabled();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, width-parametrised ALU with architectural carry/zero flag registers, conditional execution and a valid/ready input handshake. It is the next-generation execute unit of the multicycle RISC datapath. It adds subtraction, held flag state, skip reporting for conditional ops (ADC/ADZ/NDC/NDZ style) and an optional iterative multiplier.

## Interface
- WIDTH, 16, operand/result width in bits (≥4)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation this cycle
- op  in  2  00 ADD, 01 NAND, 10 SUB, 11 MUL
- cond  in  2  00 always, 01 if carry_flag, 10 if zero_flag, 11 never
- in1, in2  in  WIDTH  operands
- flags_load  in  1  overwrite flag registers (context restore)
- flags_in  in  2  {carry, zero} value for flags_load
- result  out  WIDTH  registered result
- out_valid  out  1  one-cycle pulse: operation finished (taken or skipped)
- wb_en  out  1  qualifies out_valid: 1 = taken, write result back
- carry_flag, zero_flag  out  1  architectural flag registers
- neg  out  1  result[WIDTH-1]
- busy  out  1  multi-cycle op in progress

## Operation
- Accept on the rising edge where in_valid && in_ready; inputs are sampled only then.
- Condition is evaluated at acceptance against the current flag registers. Not taken → out_valid=1, wb_en=0; result and flags unchanged.
- ADD: result = in1+in2 mod 2^WIDTH; carry = carry-out; zero = (result==0).
- SUB: result = in1+~in2+1; carry = carry-out (1 = no borrow); zero updated.
- NAND: result = ~(in1&in2); zero updated; carry unchanged.
- MUL: result = low WIDTH bits of in1*in2 (unsigned); carry = 1 if the upper WIDTH bits are nonzero; zero taken from the low half.
- flags_load in the same cycle as a flag commit: flags_load wins.
- No output backpressure: out_valid is never stalled.
- State machine: IDLE (in_ready=1) → BUSY on an accepted, taken MUL; BUSY → IDLE after the final iteration. All other ops stay in IDLE.

## Timing
- Reset values: result=0, carry_flag=0, zero_flag=0, out_valid=0, wb_en=0, in_ready=1, busy=0, state IDLE.
- ADD/SUB/NAND and all skipped ops: result, flags and out_valid are registered at the accepting edge, giving 1-cycle latency. Back-to-back acceptance is allowed every cycle. A conditional op accepted at the next edge sees the updated flags (no hazard).
- MUL taken: busy=1, in_ready=0 for WIDTH cycles after acceptance. out_valid and the flags are registered at the end of the last iteration, giving WIDTH+1 cycle latency. A new op can be accepted in the cycle out_valid is high.
- in_valid while busy is ignored; the requester holds it.
- Reset mid-MUL abandons the op: no out_valid is issued and the flags stay at their reset values.
- result holds its last value between operations.

## Configuration
- ALU_MUL_EN defined: op 11 runs the iterative multiplier as above.
- ALU_MUL_EN undefined: op 11 is illegal. It is treated as not taken (out_valid=1, wb_en=0, 1-cycle latency, flags unchanged), busy is tied to 0 and the BUSY state is removed.

## Structure
- Package alu_pkg: op encodings (OP_ADD, OP_NAND, OP_SUB, OP_MUL), cond encodings (COND_ALWAYS, COND_C, COND_Z, COND_NEVER) and the state enum.
- Sub-module alu_mul_iter (WIDTH parameter): shift-add multiplier with start/done and a 2·WIDTH product. It is instantiated only under ALU_MUL_EN.
- Adder, NAND and flag logic stay inline in alu_seq.

## Test plan
- Reset, then ADD 0xFFFF+0x0001 → next cycle result=0x0000, carry=1, zero=1, wb_en=1.
- SUB 0x0005−0x0007 → result=0xFFFE, carry=0, neg=1. A following NDZ-style NAND (cond=10) with zero=0 → out_valid=1, wb_en=0, result still 0xFFFE.
- flags_load {1,0} and ADD 0x0001+0x0001 in the same cycle → flags={1,0} (load wins), result=0x0002.
- With ALU_MUL_EN: MUL 0x0100×0x0100 → busy for 16 cycles, in_ready=0; then result=0x0000, carry=1, zero=1. An ADD presented while busy is accepted only after out_valid.
- Assert reset on the 8th MUL cycle → next cycle busy=0, in_ready=1, no out_valid, flags=0.
- Without ALU_MUL_EN: MUL 3×4 → 1-cycle out_valid with wb_en=0, flags unchanged, busy never asserted.
